cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  Single-cycle MIPS-style datapath driven by an externally supplied instruction word.
//  - Decodes R-type ALU ops, LW and SW.
//  - Contains the register file, control decode, ALU, sign-extend and a small data memory.
//  - Exposes the combinational ALU result and zero flag for top-level checking.
//  - Sits below the fetch stage; no PC or instruction memory.
// PARAMETERS
//  DMEM_WORDS  64  data-memory depth in 32-bit words (power of two)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  Instruction  in   32  current instruction; held stable for one cycle
//  ALU_Result   out  32  combinational ALU output for the current instruction
//  zero         out  1   1 when ALU_Result == 32'h0
// BEHAVIOUR
//  - Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
//  - Immediates are sign-extended to 32 bits.
//  - A = reg[rs]. B = reg[rt] for R-type, sign-extended imm for LW/SW.
//  - R-type (op 000000), by funct:
//    - 100000: A+B
//    - 100010: A-B
//    - 100100: A&B
//    - 100101: A|B
//    - 100110: A^B
//    - 100111: ~A
//    - 001000: A+1
//    - 001001: A-1
//    - All arithmetic is 32-bit modular, no overflow trap.
//  - LW (100011): ALU_Result = A + simm; writes dmem[addr] into reg[rt].
//  - SW (101011): ALU_Result = A + simm; writes reg[rt] into dmem[addr].
//  - addr = ALU_Result[log2(DMEM_WORDS)+1:2]; low two bits are ignored and the address wraps.
//  - Unknown opcode or unknown R-type funct: ALU_Result = 0 and zero = 1; no register or memory write.
//  - ALU_Result and zero are purely combinational from Instruction and register state; zero latency.
//  - Register file: 32x32, two async read ports, one write port on posedge clk.
//    - Write destination: rd for R-type, rt for LW.
//    - Writes to reg0 are discarded; reg0 always reads 0.
//    - Same-cycle read/write of one register: the read returns the old value; writes land at the edge.
//  - Reset (rst_n=0, async):
//    - reg[i] = i for i = 0..31.
//    - All dmem words = 0.
//    - Outputs follow the combinational decode of Instruction over the reset registers.
//    - Reset asserted mid-cycle aborts the pending write.
// CONFIGURATION
//  - SLT_EN defined: R-type funct 101010 computes A<B, signed comparison, result 32'h1 or 32'h0.
//    Writes go to rd like other R-type ops.
//  - SLT_EN undefined: funct 101010 is treated as an unknown funct (result 0, zero=1, no write).
// STRUCTURE
//  - Package cpu_pkg holds:
//    - opcode constants OP_RTYPE, OP_LW, OP_SW
//    - funct constants (F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOT, F_INC, F_DEC, F_SLT)
//    - ALU-op enum alu_op_t, including ALU_NOP
//  - Sub-module cpu_alu: a, b, alu_op -> result, zero.
//  - Register file, decode and dmem stay inline.
// TESTING
//  - Reset, then add $1,$2,$3 (0x00430820) -> ALU_Result=0x00000005, zero=0; reg1=5 after the edge.
//  - sub $4,$5,$6 -> 0xFFFFFFFF.
//    and $7,$8,$9 -> 0x00000008.
//    or $14,$15,$16 -> 0x0000001F.
//    xor $17,$18,$19 -> 0x00000001.
//    Each gives zero=0.
//  - lw $10,100($11) -> 0x0000006F.
//    sw $12,200($13) -> 0x000000D5.
//    Then sw $12,0($0) followed by lw $3,0($0) -> reg3=12.
//  - comp $20,$21 -> 0xFFFFFFEA.
//    inc $22,$23 -> 0x00000018.
//    dec $24,$25 -> 0x00000018.
//  - sub $1,$1,$1 -> ALU_Result=0, zero=1.
//    Undefined opcode 0xFC000000 -> 0, zero=1, no state change.
//  - rst_n pulsed low mid-cycle after writes -> all registers are back to index values, dmem is 0.
//    With SLT_EN: slt $1,$5,$2 -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode constants and ALU operation encoding for the single-cycle datapath.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOT = 6'b100111;
  localparam logic [5:0] F_INC = 6'b001000;
  localparam logic [5:0] F_DEC = 6'b001001;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_INC,
    ALU_DEC,
    ALU_SLT
  } alu_op_t;

  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// 32-bit combinational ALU; ALU_NOP yields zero so unknown instructions report zero=1.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     alu_op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = 32'h0;
    case (alu_op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_NOT: result_o = ~a_i;
      ALU_INC: result_o = a_i + 32'd1;
      ALU_DEC: result_o = a_i - 32'd1;
      ALU_SLT: result_o = {31'h0, $signed(a_i) < $signed(b_i)};
      default: result_o = 32'h0;
    endcase
  end

  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/cpu_datapath.sv
// Single-cycle MIPS-style datapath: regfile, decode, ALU and data memory, no fetch.
// Optional feature macro SLT_EN enables the signed set-less-than R-type op.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  output logic [31:0] ALU_Result,
  output logic        zero
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm;
  logic        unused_shamt;

  assign op    = Instruction[31:26];
  assign rs    = Instruction[25:21];
  assign rt    = Instruction[20:16];
  assign rd    = Instruction[15:11];
  assign funct = Instruction[5:0];
  assign simm  = sign_ext(Instruction[15:0]);
  assign unused_shamt = ^Instruction[10:6];

  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  alu_op_t     alu_op;
  logic        reg_we, mem_we, is_load, use_imm;
  logic [4:0]  wr_addr;
  logic [31:0] a_val, rt_val, b_val, wr_data_d;
  logic [AW-1:0] mem_addr;

  always_comb begin
    alu_op  = ALU_NOP;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    is_load = 1'b0;
    use_imm = 1'b0;
    wr_addr = rd;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          F_ADD: alu_op = ALU_ADD;
          F_SUB: alu_op = ALU_SUB;
          F_AND: alu_op = ALU_AND;
          F_OR:  alu_op = ALU_OR;
          F_XOR: alu_op = ALU_XOR;
          F_NOT: alu_op = ALU_NOT;
          F_INC: alu_op = ALU_INC;
          F_DEC: alu_op = ALU_DEC;
`ifdef SLT_EN
          F_SLT: alu_op = ALU_SLT;
`endif
          default: begin
            alu_op = ALU_NOP;
            reg_we = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        is_load = 1'b1;
        reg_we  = 1'b1;
        wr_addr = rt;
      end
      OP_SW: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        mem_we  = 1'b1;
      end
      default: alu_op = ALU_NOP;
    endcase
  end

  // reg0 is forced to read zero regardless of storage contents.
  assign a_val  = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : regs_q[rt];
  assign b_val  = use_imm ? simm : rt_val;

  cpu_alu u_alu (
    .a_i      (a_val),
    .b_i      (b_val),
    .alu_op_i (alu_op),
    .result_o (ALU_Result),
    .zero_o   (zero)
  );

  // Word address: byte offset dropped, upper bits wrap around the memory depth.
  assign mem_addr  = ALU_Result[AW+1:2];
  assign wr_data_d = is_load ? dmem_q[mem_addr] : ALU_Result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'(i);
    end else if (reg_we && (wr_addr != 5'd0)) begin
      regs_q[wr_addr] <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= 32'h0;
    end else if (mem_we) begin
      dmem_q[mem_addr] <= rt_val;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath; registers are observed through add $0,$r,$0 reads.
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] alu_result;
  logic        zero;

  int checks;
  int passed;
  logic [31:0] exp_q[$];

  cpu_datapath #(.DMEM_WORDS(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Instruction (instruction),
    .ALU_Result  (alu_result),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] funct);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'b0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rd_reg(input int r);
    return rtype(r, 0, 0, F_ADD);
  endfunction

  // Apply an instruction and wait to the falling edge where outputs are sampled.
  task automatic drive(input logic [31:0] instr);
    instruction = instr;
    @(negedge clk);
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(rtype(2, 3, 1, F_ADD));
    checks++;
    if (alu_result !== 32'h5 || zero !== 1'b0)
      $display("FAIL reset_decode: got %h/%b expected 00000005/0", alu_result, zero);
    else passed++;
    commit();
    rst_n = 1'b1;
    drive(rd_reg(1));
    checks++;
    if (alu_result !== 32'h1) $display("FAIL reset_no_write: got %h expected 00000001", alu_result);
    else passed++;
    drive(rd_reg(31));
    checks++;
    if (alu_result !== 32'd31) $display("FAIL reset_reg31: got %h expected 0000001f", alu_result);
    else passed++;
    commit();
  endtask

  task automatic test_rtype();
    logic [31:0] instrs [5];
    logic [31:0] exps [5];
    instrs = '{32'h00430820, rtype(5, 6, 4, F_SUB), rtype(8, 9, 7, F_AND),
               rtype(15, 16, 14, F_OR), rtype(18, 19, 17, F_XOR)};
    exps   = '{32'h5, 32'hFFFFFFFF, 32'h8, 32'h1F, 32'h1};
    for (int i = 0; i < 5; i++) begin
      drive(instrs[i]);
      checks++;
      if (alu_result !== exps[i] || zero !== 1'b0)
        $display("FAIL rtype_%0d: got %h/%b expected %h/0", i, alu_result, zero, exps[i]);
      else passed++;
      commit();
    end
    exp_q.push_back(32'h5);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h1);
    foreach (instrs[i]) begin end
    drive(rd_reg(1));
    checks++;
    if (alu_result !== exp_q.pop_front()) $display("FAIL rtype_wb_r1: got %h expected 00000005", alu_result);
    else passed++;
    drive(rd_reg(4));
    checks++;
    if (alu_result !== exp_q.pop_front()) $display("FAIL rtype_wb_r4: got %h expected ffffffff", alu_result);
    else passed++;
    drive(rd_reg(17));
    checks++;
    if (alu_result !== exp_q.pop_front()) $display("FAIL rtype_wb_r17: got %h expected 00000001", alu_result);
    else passed++;
    commit();
  endtask

  task automatic test_mem();
    logic [31:0] instrs [7];
    logic [31:0] exps [7];
    int rregs [5];
    logic [31:0] rexp [5];
    instrs = '{itype(OP_LW, 11, 10, 16'd100), itype(OP_SW, 13, 12, 16'd200),
               itype(OP_SW, 0, 12, 16'd0), itype(OP_LW, 0, 3, 16'd0),
               itype(OP_LW, 0, 2, 16'd256), itype(OP_LW, 0, 6, 16'd3),
               itype(OP_LW, 13, 9, 16'hFFFC)};
    exps   = '{32'h6F, 32'hD5, 32'h0, 32'h0, 32'h100, 32'h3, 32'h9};
    for (int i = 0; i < 7; i++) begin
      drive(instrs[i]);
      checks++;
      if (alu_result !== exps[i] || zero !== (exps[i] == 32'h0))
        $display("FAIL mem_addr_%0d: got %h/%b expected %h", i, alu_result, zero, exps[i]);
      else passed++;
      commit();
    end
    drive(itype(OP_LW, 13, 8, 16'd200));
    commit();
    rregs = '{10, 3, 2, 6, 8};
    rexp  = '{32'h0, 32'd12, 32'd12, 32'd12, 32'd12};
    for (int i = 0; i < 5; i++) begin
      drive(rd_reg(rregs[i]));
      checks++;
      if (alu_result !== rexp[i])
        $display("FAIL mem_load_r%0d: got %h expected %h", rregs[i], alu_result, rexp[i]);
      else passed++;
    end
    drive(rd_reg(9));
    checks++;
    if (alu_result !== 32'h0) $display("FAIL mem_neg_imm_r9: got %h expected 00000000", alu_result);
    else passed++;
    commit();
  endtask

  task automatic test_unary();
    logic [31:0] instrs [3];
    logic [31:0] exps [3];
    instrs = '{rtype(21, 0, 20, F_NOT), rtype(23, 0, 22, F_INC), rtype(25, 0, 24, F_DEC)};
    exps   = '{32'hFFFFFFEA, 32'h18, 32'h18};
    for (int i = 0; i < 3; i++) begin
      drive(instrs[i]);
      checks++;
      if (alu_result !== exps[i] || zero !== 1'b0)
        $display("FAIL unary_%0d: got %h/%b expected %h/0", i, alu_result, zero, exps[i]);
      else passed++;
      commit();
    end
    drive(rd_reg(20));
    checks++;
    if (alu_result !== 32'hFFFFFFEA) $display("FAIL unary_wb_r20: got %h expected ffffffea", alu_result);
    else passed++;
    commit();
  endtask

  task automatic test_zero_and_unknown();
    drive(rtype(1, 1, 1, F_SUB));
    checks++;
    if (alu_result !== 32'h0 || zero !== 1'b1)
      $display("FAIL sub_self: got %h/%b expected 00000000/1", alu_result, zero);
    else passed++;
    commit();
    drive(32'hFC000000);
    checks++;
    if (alu_result !== 32'h0 || zero !== 1'b1)
      $display("FAIL bad_opcode: got %h/%b expected 00000000/1", alu_result, zero);
    else passed++;
    commit();
    drive(32'hFC050000 | 32'h0000_0064);
    commit();
    drive(rtype(5, 6, 5, 6'h3F));
    checks++;
    if (alu_result !== 32'h0 || zero !== 1'b1)
      $display("FAIL bad_funct: got %h/%b expected 00000000/1", alu_result, zero);
    else passed++;
    commit();
    drive(rd_reg(5));
    checks++;
    if (alu_result !== 32'h5) $display("FAIL unknown_no_write_r5: got %h expected 00000005", alu_result);
    else passed++;
    commit();
  endtask

  task automatic test_reset_pulse();
    int r;
    instruction = rtype(2, 3, 1, F_ADD);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i));
    for (int i = 0; i < 32; i++) begin
      r = $urandom_range(0, 0) + i;
      drive(rd_reg(r));
      checks++;
      if (alu_result !== exp_q.pop_front())
        $display("FAIL pulse_reg%0d: got %h expected %h", r, alu_result, 32'(r));
      else passed++;
    end
    commit();
    drive(itype(OP_LW, 0, 3, 16'd0));
    commit();
    drive(itype(OP_LW, 13, 8, 16'd200));
    commit();
    drive(rd_reg(3));
    checks++;
    if (alu_result !== 32'h0) $display("FAIL pulse_dmem0: got %h expected 00000000", alu_result);
    else passed++;
    drive(rd_reg(8));
    checks++;
    if (alu_result !== 32'h0) $display("FAIL pulse_dmem53: got %h expected 00000000", alu_result);
    else passed++;
    commit();
  endtask

  task automatic test_slt();
    logic [31:0] exp_r1, exp_r7, exp_lt;
`ifdef SLT_EN
    exp_r1 = 32'h0; exp_r7 = 32'h1; exp_lt = 32'h1;
`else
    exp_r1 = 32'h1; exp_r7 = 32'h7; exp_lt = 32'h0;
`endif
    drive(rtype(5, 2, 1, F_SLT));
    checks++;
    if (alu_result !== 32'h0 || zero !== 1'b1)
      $display("FAIL slt_5_2: got %h/%b expected 00000000/1", alu_result, zero);
    else passed++;
    commit();
    drive(rtype(5, 6, 4, F_SUB));
    commit();
    drive(rtype(4, 5, 7, F_SLT));
    checks++;
    if (alu_result !== exp_lt) $display("FAIL slt_signed: got %h expected %h", alu_result, exp_lt);
    else passed++;
    commit();
    drive(rd_reg(1));
    checks++;
    if (alu_result !== exp_r1) $display("FAIL slt_wb_r1: got %h expected %h", alu_result, exp_r1);
    else passed++;
    drive(rd_reg(7));
    checks++;
    if (alu_result !== exp_r7) $display("FAIL slt_wb_r7: got %h expected %h", alu_result, exp_r7);
    else passed++;
    commit();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    instruction = 32'h0;
    test_reset();
    test_rtype();
    test_mem();
    test_unary();
    test_zero_and_unknown();
    test_reset_pulse();
    test_slt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
